// File: rtl/funct_generator_ctrl_if.sv
// Bus between the function-generator sequencer and its controller/FIFO side.
//   master : drives start/stop, waveform configuration and fifo_full;
//            observes fifo_wr_en, fifo_wdata, busy and done.
//   slave  : the sequencer itself (funct_generator_ctrl).
interface funct_generator_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  stop;
  logic [1:0]            wave_sel;
  logic [CNT_WIDTH-1:0]  period;
  logic [DATA_WIDTH-1:0] amplitude;
  logic [DATA_WIDTH-1:0] step;
  logic [CNT_WIDTH-1:0]  num_samples;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  busy;
  logic                  done;

  modport master (
    output start, stop, wave_sel, period, amplitude, step, num_samples, fifo_full,
    input  fifo_wr_en, fifo_wdata, busy, done
  );

  modport slave (
    input  start, stop, wave_sel, period, amplitude, step, num_samples, fifo_full,
    output fifo_wr_en, fifo_wdata, busy, done
  );
endinterface

// File: rtl/funct_generator_ctrl.sv
// Function-generator sequencer. Latches a waveform configuration in LOAD,
// then emits one sample per cycle into the downstream FIFO while it is not
// full. Square, sawtooth, triangle and DC; continuous or fixed sample count.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - funct_generator_ctrl_if.slave (start/stop, config, FIFO write, status)
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch config, clear phase/accumulator/count (1 cycle)
// RUN   | write one sample per cycle unless fifo_full or stop
// DONE  | num_samples written, done pulse (1 cycle)
module funct_generator_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  funct_generator_ctrl_if.slave bus
);

  localparam logic [1:0] WAVE_SQUARE = 2'b00;
  localparam logic [1:0] WAVE_SAW    = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;
  localparam logic [1:0] WAVE_DC     = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t state, state_nx;

  logic [1:0]            cfg_wave;
  logic [CNT_WIDTH-1:0]  cfg_period;
  logic [DATA_WIDTH-1:0] cfg_amp;
  logic [DATA_WIDTH-1:0] cfg_step;
  logic [CNT_WIDTH-1:0]  cfg_num;

  logic [CNT_WIDTH-1:0]  p, n;
  logic [DATA_WIDTH-1:0] v, wdata;

  logic                  wr_en;
  logic [CNT_WIDTH-1:0]  n_inc, p_nx, h;
  logic [DATA_WIDTH:0]   sum, diff, dsat;
  logic [DATA_WIDTH-1:0] v_nx, s_nx, s_init;

  function automatic logic [DATA_WIDTH-1:0] clip(input logic [DATA_WIDTH:0]   x,
                                                 input logic [DATA_WIDTH-1:0] lim);
    return (x > {1'b0, lim}) ? lim : x[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        state_nx = bus.stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nx = S_IDLE;
        end else if (!bus.fifo_full) begin
          wr_en = 1'b1;
          if (cfg_num != '0 && n_inc == cfg_num) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_wdata = wdata;

  // Next-sample datapath: everything is evaluated for the phase that follows
  // the current write, so wdata always holds the sample for the current p.
  always_comb begin
    n_inc = n + CNT_WIDTH'(1);
    h     = {1'b0, cfg_period[CNT_WIDTH-1:1]};
    p_nx  = (p == cfg_period - CNT_WIDTH'(1)) ? '0 : p + CNT_WIDTH'(1);
    sum   = {1'b0, v} + {1'b0, cfg_step};
    diff  = {1'b0, v} - {1'b0, cfg_step};
    dsat  = diff[DATA_WIDTH] ? '0 : diff;   // borrow out means v < step

    v_nx = '0;
    case (cfg_wave)
      WAVE_SAW: v_nx = (p_nx == '0) ? '0 : clip(sum, cfg_amp);
      WAVE_TRI: v_nx = (p_nx == '0) ? '0 :
                       (p_nx < h)   ? clip(sum, cfg_amp) : clip(dsat, cfg_amp);
      default:  v_nx = '0;
    endcase

    s_nx = v_nx;
    case (cfg_wave)
      WAVE_SQUARE: s_nx = (p_nx < h) ? cfg_amp : '0;
      WAVE_DC:     s_nx = cfg_amp;
      default:     s_nx = v_nx;
    endcase

    // Phase 0 sample taken straight from the inputs being latched in LOAD;
    // h is at least 1, so square starts high.
    s_init = '0;
    case (bus.wave_sel)
      WAVE_SQUARE, WAVE_DC: s_init = bus.amplitude;
      default:              s_init = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_wave   <= '0;
      cfg_period <= '0;
      cfg_amp    <= '0;
      cfg_step   <= '0;
      cfg_num    <= '0;
      p          <= '0;
      n          <= '0;
      v          <= '0;
      wdata      <= '0;
    end else if (state == S_LOAD) begin
      cfg_wave   <= bus.wave_sel;
      cfg_period <= (bus.period < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : bus.period;
      cfg_amp    <= bus.amplitude;
      cfg_step   <= bus.step;
      cfg_num    <= bus.num_samples;
      p          <= '0;
      n          <= '0;
      v          <= '0;
      wdata      <= s_init;
    end else if (wr_en) begin
      n          <= n_inc;
      p          <= p_nx;
      v          <= v_nx;
      wdata      <= s_nx;
    end
  end

endmodule

// File: tb/tb_funct_generator_ctrl.sv
// Directed bench for funct_generator_ctrl: a negedge monitor logs every FIFO
// write and done pulse; each test compares the log against hand-computed
// sample sequences.
module tb_funct_generator_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  funct_generator_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus();
  funct_generator_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int full_wr = 0;
  logic [7:0] wq[$];
  int         wcyc[$];
  int         done_cyc[$];
  logic [7:0] exq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      wq.push_back(bus.fifo_wdata);
      wcyc.push_back(cyc);
      if (bus.fifo_full) full_wr++;
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wcyc.delete();
    done_cyc.delete();
    full_wr = 0;
  endtask

  task automatic cfg(input logic [1:0] ws, input logic [15:0] per, input logic [7:0] amp,
                     input logic [7:0] stp, input logic [15:0] num);
    bus.wave_sel    = ws;
    bus.period      = per;
    bus.amplitude   = amp;
    bus.step        = stp;
    bus.num_samples = num;
  endtask

  task automatic pulse_start(output int c);
    c = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) return;
      tick();
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_writes(input int k, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (wq.size() >= k) return;
      tick();
    end
    chk(tag, wq.size(), k);
  endtask

  task automatic do_stop(input string tag);
    bus.stop = 1'b1;
    @(negedge clk);
    chk({tag, "_stop_no_wr"}, 32'(bus.fifo_wr_en), 32'd0);
    chk({tag, "_stop_busy"}, 32'(bus.busy), 32'd1);
    tick();
    bus.stop = 1'b0;
    chk({tag, "_stop_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, wq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < wq.size(); i++)
      chk($sformatf("%s_s%0d", tag, i), 32'(wq[i]), 32'(exq[i]));
  endtask

  int c0;
  int nsave;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.fifo_full = 1'b0;
    cfg(2'b00, 16'd0, 8'h00, 8'h00, 16'd0);
    tick(); tick();
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_done",  32'(bus.done),       32'd0);
    rst = 1'b0;
    tick();

    // Square, period 4, amplitude A0, 8 samples
    clear_log();
    cfg(2'b00, 16'd4, 8'hA0, 8'h00, 16'd8);
    pulse_start(c0);
    wait_idle("sq_timeout");
    tick();
    exq = '{8'hA0, 8'hA0, 8'h00, 8'h00, 8'hA0, 8'hA0, 8'h00, 8'h00};
    chk_seq("sq");
    if (wcyc.size() > 0) chk("sq_first_latency", wcyc[0], c0 + 2);
    chk("sq_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && wcyc.size() == 8) chk("sq_done_time", done_cyc[0], wcyc[7] + 1);

    // Sawtooth, period 4, step 3, amplitude 5, continuous
    clear_log();
    cfg(2'b01, 16'd4, 8'h05, 8'h03, 16'd0);
    pulse_start(c0);
    wait_writes(8, "saw_timeout");
    do_stop("saw");
    exq = '{8'h00, 8'h03, 8'h05, 8'h05, 8'h00, 8'h03, 8'h05, 8'h05};
    chk_seq("saw");
    chk("saw_no_done", done_cyc.size(), 0);

    // Triangle, period 6, step 2, amplitude FF; start and new config mid-run ignored
    clear_log();
    cfg(2'b10, 16'd6, 8'hFF, 8'h02, 16'd0);
    pulse_start(c0);
    wait_writes(3, "tri_timeout_a");
    cfg(2'b00, 16'd2, 8'h11, 8'h09, 16'd5);
    pulse_start(c0);
    wait_writes(12, "tri_timeout_b");
    do_stop("tri");
    exq = '{8'h00, 8'h02, 8'h04, 8'h02, 8'h00, 8'h00,
            8'h00, 8'h02, 8'h04, 8'h02, 8'h00, 8'h00};
    chk_seq("tri");

    // Backpressure: square period 2, fifo_full toggles, 6 samples
    clear_log();
    cfg(2'b00, 16'd2, 8'h55, 8'h00, 16'd6);
    pulse_start(c0);
    for (int i = 0; i < 100 && bus.busy; i++) begin
      bus.fifo_full = (i % 2) == 1;
      tick();
    end
    bus.fifo_full = 1'b0;
    wait_idle("bp_timeout");
    tick();
    exq = '{8'h55, 8'h00, 8'h55, 8'h00, 8'h55, 8'h00};
    chk_seq("bp");
    chk("bp_wr_while_full", full_wr, 0);
    chk("bp_done_cnt", done_cyc.size(), 1);

    // period 0 behaves as 2
    clear_log();
    cfg(2'b00, 16'd0, 8'h33, 8'h00, 16'd4);
    pulse_start(c0);
    wait_idle("p0_timeout");
    tick();
    exq = '{8'h33, 8'h00, 8'h33, 8'h00};
    chk_seq("p0");

    // DC, one sample
    clear_log();
    cfg(2'b11, 16'd5, 8'h7E, 8'h00, 16'd1);
    pulse_start(c0);
    wait_idle("dc_timeout");
    tick();
    exq = '{8'h7E};
    chk_seq("dc");
    chk("dc_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && wcyc.size() > 0) chk("dc_done_time", done_cyc[0], wcyc[0] + 1);

    // start and stop together in IDLE: LOAD then back to IDLE, no writes
    clear_log();
    cfg(2'b01, 16'd4, 8'h05, 8'h03, 16'd0);
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ss_load_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.stop = 1'b0;
    chk("ss_idle", 32'(bus.busy), 32'd0);
    tick(); tick(); tick();
    chk("ss_no_writes", wq.size(), 0);

    // Reset mid-run
    clear_log();
    cfg(2'b01, 16'd4, 8'h05, 8'h03, 16'd0);
    pulse_start(c0);
    wait_writes(2, "rr_timeout");
    nsave = wq.size();
    #1 rst = 1'b1;
    #1;
    chk("rr_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rr_wdata", 32'(bus.fifo_wdata), 32'd0);
    chk("rr_busy",  32'(bus.busy),       32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rr_idle_after", 32'(bus.busy), 32'd0);
    chk("rr_no_more_writes", wq.size(), nsave);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
